// File: rtl/niu_fetch_unit.sv
// niu_fetch_unit: Niu32 instruction-fetch stage owning PC and IR, one outstanding imem read.
// Define NIU_FETCH_PREFETCH_EN to add a one-entry prefetch buffer; the default build has none.
module niu_fetch_unit #(
   parameter int                   WORD_SIZE       = 32,
   parameter int                   INSTR_SIZE      = 4,
   parameter int                   MEM_ADDR_BITS   = 13,
   parameter int                   MEM_WORD_OFFSET = 2,
   parameter logic [WORD_SIZE-1:0] PC_STARTLOC     = 32'h0
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     ld_pc,
   input  logic [WORD_SIZE-1:0]                     pc_in,
   output logic                                     imem_req,
   output logic [MEM_ADDR_BITS-MEM_WORD_OFFSET-1:0] imem_addr,
   input  logic [WORD_SIZE-1:0]                     imem_rdata,
   input  logic                                     imem_rvalid,
   output logic [WORD_SIZE-1:0]                     ir_out,
   output logic [WORD_SIZE-1:0]                     ir_pc,
   output logic                                     ir_valid,
   input  logic                                     ir_ready,
   output logic [WORD_SIZE-1:0]                     pc_out,
   output logic                                     misalign_fault
);

   localparam int                         AW         = MEM_ADDR_BITS - MEM_WORD_OFFSET;
   localparam logic [WORD_SIZE-1:0]       PC_INC     = WORD_SIZE'(INSTR_SIZE);
   localparam logic [MEM_WORD_OFFSET-1:0] ALIGN_ZERO = {MEM_WORD_OFFSET{1'b0}};

   localparam logic [2:0] ST_FETCH = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_HOLD  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   logic [2:0]           state_r,    state_s;
   logic [WORD_SIZE-1:0] pc_r,       pc_s;
   logic [WORD_SIZE-1:0] ir_r,       ir_s;
   logic [WORD_SIZE-1:0] ir_pc_r,    ir_pc_s;
   logic                 ir_valid_r, ir_valid_s;
   logic                 req_r,      req_s;
   logic [AW-1:0]        addr_r,     addr_s;
   logic                 fault_r,    fault_s;

   logic [WORD_SIZE-1:0] pc_inc_s;
   logic                 misalign_s;
   logic                 read_open_s;
   logic                 pf_req_s;
   logic [AW-1:0]        pf_addr_s;

`ifdef NIU_FETCH_PREFETCH_EN
   logic                 pf_valid_r, pf_valid_s;
   logic                 pf_pend_r,  pf_pend_s;
   logic [WORD_SIZE-1:0] pf_data_r,  pf_data_s;
   logic [WORD_SIZE-1:0] pc_pf_s;
`endif

   assign imem_req       = req_r;
   assign imem_addr      = addr_r;
   assign ir_out         = ir_r;
   assign ir_pc          = ir_pc_r;
   assign ir_valid       = ir_valid_r;
   assign pc_out         = pc_r;
   assign misalign_fault = fault_r;

   // Next-state, PC/IR update and request generation.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      ir_s       = ir_r;
      ir_pc_s    = ir_pc_r;
      ir_valid_s = ir_valid_r;
      fault_s    = fault_r;
      req_s      = 1'b0;
      addr_s     = addr_r;
      pf_req_s   = 1'b0;
      pf_addr_s  = addr_r;
      pc_inc_s   = pc_r + PC_INC;
      misalign_s = (pc_in[MEM_WORD_OFFSET-1:0] != ALIGN_ZERO);
      // A FETCH cycle with req_r high has already put a read on the bus.
      read_open_s = (state_r == ST_WAIT) || (state_r == ST_DRAIN) ||
                    ((state_r == ST_FETCH) && req_r);
`ifdef NIU_FETCH_PREFETCH_EN
      pf_valid_s  = pf_valid_r;
      pf_pend_s   = pf_pend_r;
      pf_data_s   = pf_data_r;
      pc_pf_s     = pc_inc_s + PC_INC;
      read_open_s = read_open_s || pf_pend_r;
`endif

      if (state_r == ST_FAULT) begin
         state_s = ST_FAULT;
      end else if (ld_pc) begin
         ir_valid_s = 1'b0;
`ifdef NIU_FETCH_PREFETCH_EN
         pf_valid_s = 1'b0;
         pf_pend_s  = 1'b0;
`endif
         if (misalign_s) begin
            fault_s = 1'b1;
            state_s = ST_FAULT;
         end else begin
            pc_s = pc_in;
            if (read_open_s && !imem_rvalid) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_FETCH;
            end
         end
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (req_r) begin
                  state_s = ST_WAIT;
               end else begin
                  state_s = ST_FETCH;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  ir_s       = imem_rdata;
                  ir_pc_s    = pc_r;
                  ir_valid_s = 1'b1;
                  state_s    = ST_HOLD;
`ifdef NIU_FETCH_PREFETCH_EN
                  pf_req_s   = 1'b1;
                  pf_addr_s  = pc_inc_s[MEM_ADDR_BITS-1:MEM_WORD_OFFSET];
                  pf_pend_s  = 1'b1;
`endif
               end else begin
                  state_s = ST_WAIT;
               end
            end
            ST_HOLD: begin
`ifdef NIU_FETCH_PREFETCH_EN
               if (pf_pend_r && imem_rvalid) begin
                  pf_valid_s = 1'b1;
                  pf_data_s  = imem_rdata;
                  pf_pend_s  = 1'b0;
               end else begin
                  pf_data_s  = pf_data_r;
               end
               if (ir_valid_r && ir_ready) begin
                  pc_s = pc_inc_s;
                  if (pf_valid_r || (pf_pend_r && imem_rvalid)) begin
                     // Back-to-back: next instruction comes from the buffer or the bus.
                     ir_s       = pf_valid_r ? pf_data_r : imem_rdata;
                     ir_pc_s    = pc_inc_s;
                     pf_valid_s = 1'b0;
                     pf_pend_s  = 1'b1;
                     pf_req_s   = 1'b1;
                     pf_addr_s  = pc_pf_s[MEM_ADDR_BITS-1:MEM_WORD_OFFSET];
                     state_s    = ST_HOLD;
                  end else if (pf_pend_r) begin
                     ir_valid_s = 1'b0;
                     pf_pend_s  = 1'b0;
                     state_s    = ST_WAIT;
                  end else begin
                     ir_valid_s = 1'b0;
                     state_s    = ST_FETCH;
                  end
               end else begin
                  state_s = ST_HOLD;
               end
`else
               if (ir_valid_r && ir_ready) begin
                  ir_valid_s = 1'b0;
                  pc_s       = pc_inc_s;
                  state_s    = ST_FETCH;
               end else begin
                  state_s = ST_HOLD;
               end
`endif
            end
            ST_DRAIN: begin
               if (imem_rvalid) begin
                  state_s = ST_FETCH;
               end else begin
                  state_s = ST_DRAIN;
               end
            end
            default: begin
               state_s = ST_FETCH;
            end
         endcase
      end

      if (state_s == ST_FETCH) begin
         req_s  = 1'b1;
         addr_s = pc_s[MEM_ADDR_BITS-1:MEM_WORD_OFFSET];
      end else if (pf_req_s) begin
         req_s  = 1'b1;
         addr_s = pf_addr_s;
      end else begin
         req_s  = 1'b0;
         addr_s = addr_r;
      end
   end

   // State and datapath registers; reset leaves FETCH with no request so a stale rvalid is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_FETCH;
         pc_r       <= PC_STARTLOC;
         ir_r       <= {WORD_SIZE{1'b0}};
         ir_pc_r    <= {WORD_SIZE{1'b0}};
         ir_valid_r <= 1'b0;
         req_r      <= 1'b0;
         addr_r     <= {AW{1'b0}};
         fault_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         ir_r       <= ir_s;
         ir_pc_r    <= ir_pc_s;
         ir_valid_r <= ir_valid_s;
         req_r      <= req_s;
         addr_r     <= addr_s;
         fault_r    <= fault_s;
      end
   end

`ifdef NIU_FETCH_PREFETCH_EN
   // Prefetch buffer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pf_valid_r <= 1'b0;
         pf_pend_r  <= 1'b0;
         pf_data_r  <= {WORD_SIZE{1'b0}};
      end else begin
         pf_valid_r <= pf_valid_s;
         pf_pend_r  <= pf_pend_s;
         pf_data_r  <= pf_data_s;
      end
   end
`endif

endmodule

// File: tb/tb_niu_fetch_unit.sv
// Directed self-checking bench for niu_fetch_unit with a variable-latency imem responder.
module tb_niu_fetch_unit;

   logic        clk;
   logic        reset;
   logic        ld_pc;
   logic [31:0] pc_in;
   logic        imem_req;
   logic [10:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] ir_out;
   logic [31:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] pc_out;
   logic        misalign_fault;

   int          n_cmp;
   int          n_err;
   int          mem_lat;
   int          rsp_cnt;
   logic [10:0] rsp_addr;
   int          n_cons;

   niu_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .ld_pc          (ld_pc),
      .pc_in          (pc_in),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .ir_out         (ir_out),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .pc_out         (pc_out),
      .misalign_fault (misalign_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [10:0] a);
      return 32'hA500_0000 | {21'h0, a};
   endfunction

   // Instruction memory: rvalid appears mem_lat cycles after the request cycle.
   always @(posedge clk) begin
      if (reset) begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= 32'h0;
         rsp_cnt     <= 0;
         rsp_addr    <= 11'h0;
      end else begin
         imem_rvalid <= 1'b0;
         if (imem_req && mem_lat == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= mem_word(imem_addr);
         end else if (imem_req) begin
            rsp_cnt  <= mem_lat - 1;
            rsp_addr <= imem_addr;
         end else if (rsp_cnt != 0) begin
            rsp_cnt <= rsp_cnt - 1;
            if (rsp_cnt == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem_word(rsp_addr);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      n_cons   = 0;
      reset    = 1'b1;
      ld_pc    = 1'b0;
      pc_in    = 32'h0;
      ir_ready = 1'b0;
      mem_lat  = 1;
      repeat (3) @(negedge clk);

      chk("rst_pc",       pc_out,         32'h0);
      chk("rst_ir",       ir_out,         32'h0);
      chk("rst_ir_pc",    ir_pc,          32'h0);
      chk("rst_ir_valid", 32'(ir_valid),  32'h0);
      chk("rst_req",      32'(imem_req),  32'h0);
      chk("rst_fault",    32'(misalign_fault), 32'h0);

      // Sequential fetch at latency 1, controller always ready.
      reset    = 1'b0;
      ir_ready = 1'b1;
      chk("t1_req_idle", 32'(imem_req), 32'h0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("t1_req", 32'(imem_req), 32'(i % 3 == 0));
         if (i % 3 == 0) chk("t1_addr", 32'(imem_addr), 32'(i / 3));
         if (i % 3 == 2) begin
            chk("t1_valid", 32'(ir_valid), 32'h1);
            chk("t1_ir_pc", ir_pc, 32'(4 * (i / 3)));
            chk("t1_ir_out", ir_out, mem_word(11'(i / 3)));
         end
      end

      // Stall in HOLD: IR stable, no new requests.
      ir_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_valid", 32'(ir_valid), 32'h1);
         chk("t2_ir_out", ir_out, mem_word(11'd2));
         chk("t2_req", 32'(imem_req), 32'h0);
         chk("t2_pc", pc_out, 32'h8);
      end

      // Redirect while a latency-3 read is in flight.
      mem_lat  = 3;
      ir_ready = 1'b1;
      @(negedge clk);
      ir_ready = 1'b0;
      chk("t3_req", 32'(imem_req), 32'h1);
      chk("t3_addr", 32'(imem_addr), 32'h3);
      @(negedge clk);
      chk("t3_wait_req", 32'(imem_req), 32'h0);
      ld_pc = 1'b1;
      pc_in = 32'h40;
      @(negedge clk);
      ld_pc = 1'b0;
      chk("t3_pc", pc_out, 32'h40);
      chk("t3_valid_drop", 32'(ir_valid), 32'h0);
      chk("t3_drain_req", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("t3_drain_req2", 32'(imem_req), 32'h0);
      @(negedge clk);
      chk("t3_new_req", 32'(imem_req), 32'h1);
      chk("t3_new_addr", 32'(imem_addr), 32'h10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_wait_valid", 32'(ir_valid), 32'h0);
      end
      @(negedge clk);
      chk("t3_valid", 32'(ir_valid), 32'h1);
      chk("t3_ir_pc", ir_pc, 32'h40);
      chk("t3_ir_out", ir_out, mem_word(11'h10));

      // Redirect together with a consume: the consume is ignored.
      mem_lat  = 1;
      ld_pc    = 1'b1;
      pc_in    = 32'h80;
      ir_ready = 1'b1;
      @(negedge clk);
      ld_pc    = 1'b0;
      ir_ready = 1'b0;
      chk("t4_valid", 32'(ir_valid), 32'h0);
      chk("t4_pc", pc_out, 32'h80);
      chk("t4_req", 32'(imem_req), 32'h1);
      chk("t4_addr", 32'(imem_addr), 32'h20);
      repeat (2) @(negedge clk);
      chk("t4_valid2", 32'(ir_valid), 32'h1);
      chk("t4_ir_pc", ir_pc, 32'h80);
      chk("t4_ir_out", ir_out, mem_word(11'h20));

      // Misaligned redirect: sticky fault, requests stop, aligned redirect ignored.
      ld_pc = 1'b1;
      pc_in = 32'h42;
      @(negedge clk);
      chk("t5_fault", 32'(misalign_fault), 32'h1);
      chk("t5_valid", 32'(ir_valid), 32'h0);
      pc_in = 32'h100;
      @(negedge clk);
      ld_pc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t5_req", 32'(imem_req), 32'h0);
         chk("t5_fault_sticky", 32'(misalign_fault), 32'h1);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("t5_rst_pc", pc_out, 32'h0);
      chk("t5_rst_fault", 32'(misalign_fault), 32'h0);
      chk("t5_rst_valid", 32'(ir_valid), 32'h0);

      // Consecutive consumes after reset step ir_pc by 4 from the start location.
      reset    = 1'b0;
      ir_ready = 1'b1;
      for (int c = 0; c < 40 && n_cons < 4; c++) begin
         @(negedge clk);
         if (ir_valid && ir_ready) begin
            chk("t6_ir_pc", ir_pc, 32'(4 * n_cons));
            chk("t6_ir_out", ir_out, mem_word(11'(n_cons)));
            n_cons++;
         end
      end
      chk("t6_consumes", 32'(n_cons), 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
